// File: rtl/rglib_rotate_pipe_pkg.sv
// rglib_rotate_pkg: shared mode encoding and the single-stage rotate/shift helper.
package rglib_rotate_pkg;
  localparam int MAX_W = 256;
  localparam int IW = $clog2(MAX_W);
  typedef enum logic [2:0] {ROL, ROR, SLL, SRL, SRA} mode_e;
  // Applies one log-stage shift of shift_pow to the low width bits; codes above SRA pass through.
  function automatic logic [MAX_W-1:0] rot_stage(input logic [MAX_W-1:0] data, input int width,
                                                 input int shift_pow, input mode_e mode, input logic en);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < width; i++)
      r[i] = !en || mode > SRA ? data[IW'(i)] :
             mode == ROL ? data[IW'((i - shift_pow + width) % width)] :
             mode == ROR ? data[IW'((i + shift_pow) % width)] :
             mode == SLL ? (i >= shift_pow ? data[IW'(i - shift_pow)] : 1'b0) :
             i + shift_pow < width ? data[IW'(i + shift_pow)] :
             mode == SRA ? data[IW'(width - 1)] : 1'b0;
    return r;
  endfunction
endpackage

// File: rtl/rglib_rotate_lane.sv
// rglib_rotate_lane: combinational log-shifter slice for one stage of one lane.
import rglib_rotate_pkg::*;
module rglib_rotate_lane #(
  parameter int DATA_WIDTH = 32,
  parameter int STAGE = 0
)(
  input  logic [DATA_WIDTH-1:0] d,
  input  logic                  en,
  input  mode_e                 mode,
  output logic [DATA_WIDTH-1:0] q
);
  assign q = DATA_WIDTH'(rot_stage(MAX_W'(d), DATA_WIDTH, 1 << STAGE, mode, en));
endmodule

// File: rtl/rglib_rotate_pipe.sv
// rglib_rotate_pipe: pipelined multi-lane rotate/shift with valid/ready backpressure.
// Optional beat counter port beat_cnt enabled by RGLIB_ROTATE_PIPE_CNT_EN.
import rglib_rotate_pkg::*;
module rglib_rotate_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int LANE_NUM = 1,
  parameter logic [$clog2(DATA_WIDTH)-1:0] REG_MASK = 'b10100
)(
  input  logic                                   clk,
  input  logic                                   kill,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [LANE_NUM*DATA_WIDTH-1:0]         in,
  input  logic [LANE_NUM*$clog2(DATA_WIDTH)-1:0] rotate_val,
  input  mode_e                                  mode,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [LANE_NUM*DATA_WIDTH-1:0]         out
`ifdef RGLIB_ROTATE_PIPE_CNT_EN
  , output logic [31:0]                          beat_cnt
`endif
);
  localparam int RS = $clog2(DATA_WIDTH);
  localparam int LW = LANE_NUM * DATA_WIDTH;
  localparam logic [RS-1:0] MASK = REG_MASK | (RS'(1) << (RS - 1));
  if (DATA_WIDTH < 2 || (DATA_WIDTH & (DATA_WIDTH - 1)) != 0 || DATA_WIDTH > MAX_W) begin : g_bad_width
    $error("rglib_rotate_pipe: DATA_WIDTH must be a power of two in 2..%0d", MAX_W);
  end
  logic [LW-1:0] d [RS+1];
  logic v [RS+1];
  logic r [RS+1];
  logic [LANE_NUM*RS-1:0] a [RS];
  mode_e m [RS];
  assign d[0] = in;
  assign v[0] = in_valid;
  assign a[0] = rotate_val;
  assign m[0] = mode;
  assign r[RS] = out_ready;
  assign in_ready = r[0];
  assign out = d[RS];
  assign out_valid = v[RS];
  for (genvar s = 0; s < RS; s++) begin : g_stage
    logic [LW-1:0] c;
    for (genvar l = 0; l < LANE_NUM; l++) begin : g_lane
      rglib_rotate_lane #(.DATA_WIDTH(DATA_WIDTH), .STAGE(s)) u_lane (
        .d(d[s][l*DATA_WIDTH +: DATA_WIDTH]),
        .en(a[s][l*RS + s]),
        .mode(m[s]),
        .q(c[l*DATA_WIDTH +: DATA_WIDTH])
      );
    end
    if (MASK[s]) begin : g_reg
      logic vq;
      logic [LW-1:0] dq;
      always_ff @(posedge clk)
        if (!kill) begin
          vq <= 1'b0;
          dq <= '0;
        end else if (r[s]) begin
          vq <= v[s];
          dq <= c;
        end
      assign r[s] = !vq || r[s+1];
      assign v[s+1] = vq;
      assign d[s+1] = dq;
      if (s < RS - 1) begin : g_ctl
        logic [LANE_NUM*RS-1:0] aq;
        mode_e mq;
        always_ff @(posedge clk)
          if (!kill) begin
            aq <= '0;
            mq <= ROL;
          end else if (r[s]) begin
            aq <= a[s];
            mq <= m[s];
          end
        assign a[s+1] = aq;
        assign m[s+1] = mq;
      end
    end else begin : g_comb
      assign r[s] = r[s+1];
      assign v[s+1] = v[s];
      assign d[s+1] = c;
      assign a[s+1] = a[s];
      assign m[s+1] = m[s];
    end
  end
`ifdef RGLIB_ROTATE_PIPE_CNT_EN
  always_ff @(posedge clk)
    if (!kill) beat_cnt <= '0;
    else if (out_valid && out_ready) beat_cnt <= beat_cnt + 32'd1;
`endif
endmodule

// File: tb/tb_rglib_rotate_pipe.sv
// tb_rglib_rotate_pipe: scoreboard bench for a 4-lane, 8-bit, two-register rotate pipe.
module tb_rglib_rotate_pipe;
  import rglib_rotate_pkg::*;
  localparam int DW = 8, LN = 4, RS = 3;
  logic clk = 0, kill = 0, in_valid = 0, out_ready = 1;
  logic in_ready, out_valid;
  logic [LN*DW-1:0] din = '0, dout;
  logic [LN*RS-1:0] amt = '0;
  mode_e mode = ROL;
`ifdef RGLIB_ROTATE_PIPE_CNT_EN
  logic [31:0] beat_cnt;
`endif
  always #5 clk = ~clk;

  rglib_rotate_pipe #(.DATA_WIDTH(DW), .LANE_NUM(LN), .REG_MASK(3'b101)) dut (
    .clk(clk), .kill(kill), .in_valid(in_valid), .in_ready(in_ready), .in(din),
    .rotate_val(amt), .mode(mode), .out_valid(out_valid), .out_ready(out_ready), .out(dout)
`ifdef RGLIB_ROTATE_PIPE_CNT_EN
    , .beat_cnt(beat_cnt)
`endif
  );

  typedef struct {logic [31:0] e; int c;} exp_t;
  exp_t q[$];
  int nchk = 0, nerr = 0, cyc = 0, npop = 0, waits = 0;
  bit lat_chk = 1, saw_full = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    nchk++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [7:0] ref1(input logic [7:0] x, input int n, input logic [2:0] md);
    logic [15:0] xx;
    xx = {x, x};
    case (md)
      3'd0: return 8'((xx << n) >> 8);
      3'd1: return 8'(xx >> n);
      3'd2: return 8'(x << n);
      3'd3: return 8'(x >> n);
      3'd4: return 8'($signed(x) >>> n);
      default: return x;
    endcase
  endfunction

  function automatic logic [31:0] model(input logic [31:0] dd, input logic [11:0] aa, input logic [2:0] md);
    logic [31:0] res;
    for (int l = 0; l < LN; l++) res[l*8 +: 8] = ref1(dd[l*8 +: 8], int'(aa[l*3 +: 3]), md);
    return res;
  endfunction

  task automatic send(input logic [31:0] dd, input logic [11:0] aa, input logic [2:0] mm,
                      input bit use_e, input logic [31:0] ee);
    bit acc;
    acc = 0;
    @(negedge clk);
    in_valid = 1; din = dd; amt = aa; mode = mode_e'(mm);
    for (int t = 0; t < 100 && !acc; t++) begin
      if (t > 0) begin
        @(negedge clk);
        waits++;
      end
      #4 acc = in_ready && kill;
      if (acc) q.push_back('{e: use_e ? ee : model(dd, aa, mm), c: cyc});
      @(posedge clk);
    end
    if (!acc) chk("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_rand();
    send($urandom, 12'($urandom), 3'($urandom_range(0, 7)), 0, 32'd0);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic drain();
    for (int t = 0; t < 50 && q.size() > 0; t++) @(negedge clk);
    chk("drain", 64'(q.size()), 64'd0);
  endtask

  logic [31:0] hold_d;
  bit hold_v = 0;
  exp_t it;
  always begin
    @(negedge clk);
    #4;
    if (!kill) begin
      q.delete();
      hold_v = 0;
    end else begin
      if (!in_ready) saw_full = 1;
      if (hold_v) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_data", 64'(dout), 64'(hold_d));
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("unexpected_beat", 64'd1, 64'd0);
        else begin
          it = q.pop_front();
          npop++;
          chk("data", 64'(dout), 64'(it.e));
          if (lat_chk) chk("latency", 64'(cyc - it.c), 64'd2);
        end
      end
      hold_v = out_valid && !out_ready;
      hold_d = dout;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int p0;
    repeat (2) @(negedge clk);
    #4;
    chk("reset_valid", 64'(out_valid), 64'd0);
    chk("reset_out", 64'(dout), 64'd0);
    @(negedge clk);
    kill = 1;
    #4 chk("reset_in_ready", 64'(in_ready), 64'd1);
    send(32'hA5, 12'd3, 3'd0, 1, 32'h2D);
    send(32'hA5, 12'd1, 3'd1, 1, 32'hD2);
    send(32'hA5, 12'd2, 3'd4, 1, 32'hE9);
    send(32'hA5, 12'd4, 3'd3, 1, 32'h0A);
    send(32'hA5, 12'd4, 3'd2, 1, 32'h50);
    send(32'hA5, 12'd3, 3'd6, 1, 32'hA5);
    for (int md = 0; md < 8; md++) send(32'h80808080, 12'd0, 3'(md), 1, 32'h80808080);
    send(32'h81818181, {3'd3, 3'd7, 3'd1, 3'd0}, 3'd0, 1, 32'h0CC00381);
    idle();
    drain();
    lat_chk = 0;
    saw_full = 0;
    p0 = npop;
    fork
      begin
        for (int i = 0; i < 6; i++) send_rand();
        idle();
      end
      begin
        @(negedge clk);
        out_ready = 0;
        repeat (4) @(negedge clk);
        out_ready = 1;
      end
    join
    drain();
    chk("bp_in_ready_drop", 64'(saw_full), 64'd1);
    chk("bp_count", 64'(npop - p0), 64'd6);
    lat_chk = 1;
    send_rand();
    send_rand();
    @(negedge clk);
    in_valid = 0;
    kill = 0;
    @(negedge clk);
    kill = 1;
    #4;
    chk("kill_valid", 64'(out_valid), 64'd0);
    chk("kill_out", 64'(dout), 64'd0);
    chk("kill_in_ready", 64'(in_ready), 64'd1);
`ifdef RGLIB_ROTATE_PIPE_CNT_EN
    chk("kill_beat_cnt", 64'(beat_cnt), 64'd0);
`endif
    repeat (6) @(negedge clk);
    waits = 0;
    p0 = npop;
    for (int i = 0; i < 100; i++) send_rand();
    idle();
    drain();
    chk("tp_stalls", 64'(waits), 64'd0);
    chk("tp_count", 64'(npop - p0), 64'd100);
`ifdef RGLIB_ROTATE_PIPE_CNT_EN
    chk("tp_beat_cnt", 64'(beat_cnt), 64'd100);
`endif
    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
